irq_sequencer_n: RTL and testbench



---
 rtl/irq_sequencer_n.sv | 192 +++++++++++++++++++
 tb/tb_irq_sequencer_n.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer_n.sv
// Interrupt sequencer for the 6502-style core: arbitrates sources plus BRK at instruction
// boundaries, fetches the vector and stacks PC/P, or unwinds an RTI, or passes registers through.
module irq_sequencer_n #(
    parameter int unsigned          NUM_SRC     = 4,
    parameter logic [15:0]          VEC_BASE    = 16'hFFF8,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK   = 4'b0011,
    parameter logic [NUM_SRC-1:0]   MASKABLE    = 4'b1000,
    parameter logic [NUM_SRC-1:0]   NOPUSH_MASK = 4'b0010,
    parameter int unsigned          BRK_SRC     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               start,
    input  logic               is_rti,
    input  logic               brk,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [15:0]        pc_in,
    input  logic [7:0]         status_in,
    input  logic [7:0]         sp_in,
    output logic               done,
    output logic               busy,
    output logic [15:0]        pc_out,
    output logic [7:0]         status_out,
    output logic [7:0]         sp_out,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    input  logic [7:0]         mem_rdata,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service
);

    localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [3:0] {
        StIdle, StVecLo, StVecHi, StPushH, StPushL, StPushP,
        StPopP, StPopL, StPopH, StFin, StDone
    } state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] src_prev_q, edge_pend_q, win_q;
    logic               brk_q, nopush_q, mem_we_q;
    logic [7:0]         vec_lo_q, vec_hi_q, pop_p_q, pop_l_q;

    logic [NUM_SRC-1:0] rise, isr_low, allowed, masked, brk_req, req, win_oh, clr;
    logic [IW-1:0]      win_idx;
    logic [15:0]        vec_addr;

    assign rise    = src_in & ~src_prev_q;
    assign pending = (edge_pend_q & EDGE_MASK) | (src_in & ~EDGE_MASK);
    assign isr_low = in_service & (~in_service + NUM_SRC'(1));
    // Only sources strictly above the highest-priority one in service may nest.
    assign allowed = (in_service == '0) ? '1 : (isr_low - NUM_SRC'(1));
    assign masked  = MASKABLE & {NUM_SRC{status_in[2]}};
    assign brk_req = brk ? (NUM_SRC'(1) << BRK_SRC) : '0;
    assign req     = (pending & ~masked & allowed) | brk_req;
    assign win_oh  = req & (~req + NUM_SRC'(1));
    assign clr     = (state_q == StVecHi) ? win_q : '0;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IW'(i);
        end
    end

    assign vec_addr = VEC_BASE + 16'({win_idx, 1'b0});
    assign busy     = (state_q != StIdle);
    assign mem_we   = mem_we_q & ~halt;

    // Edge latches; a new rising edge wins over the clear from the entry's VEC_HI cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev_q  <= '0;
            edge_pend_q <= '0;
        end else if (!halt) begin
            src_prev_q  <= src_in;
            edge_pend_q <= ((edge_pend_q & ~clr) | rise) & EDGE_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            done       <= 1'b0;
            pc_out     <= '0;
            status_out <= '0;
            sp_out     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we_q   <= 1'b0;
            in_service <= '0;
            win_q      <= '0;
            brk_q      <= 1'b0;
            nopush_q   <= 1'b0;
            vec_lo_q   <= '0;
            vec_hi_q   <= '0;
            pop_p_q    <= '0;
            pop_l_q    <= '0;
        end else if (!halt) begin
            done     <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_rti) begin
                            mem_addr <= {8'h01, sp_in + 8'd1};
                            state_q  <= StPopP;
                        end else if (req != '0) begin
                            win_q    <= win_oh;
                            brk_q    <= brk;
                            nopush_q <= |(win_oh & NOPUSH_MASK);
                            mem_addr <= vec_addr;
                            state_q  <= StVecLo;
                        end else begin
                            pc_out     <= pc_in;
                            status_out <= status_in;
                            sp_out     <= sp_in;
                            done       <= 1'b1;
                            state_q    <= StDone;
                        end
                    end
                end
                StVecLo: begin
                    mem_addr <= mem_addr + 16'd1;
                    state_q  <= StVecHi;
                end
                StVecHi: begin
                    vec_lo_q  <= mem_rdata;
                    mem_addr  <= {8'h01, sp_in};
                    mem_wdata <= pc_in[15:8];
                    mem_we_q  <= ~nopush_q;
                    state_q   <= StPushH;
                end
                StPushH: begin
                    vec_hi_q  <= mem_rdata;
                    mem_addr  <= {8'h01, sp_in - 8'd1};
                    mem_wdata <= pc_in[7:0];
                    mem_we_q  <= ~nopush_q;
                    state_q   <= StPushL;
                end
                StPushL: begin
                    mem_addr  <= {8'h01, sp_in - 8'd2};
                    mem_wdata <= (status_in & 8'hEF) | 8'h20 | (brk_q ? 8'h10 : 8'h00);
                    mem_we_q  <= ~nopush_q;
                    state_q   <= StPushP;
                end
                StPushP: begin
                    pc_out     <= {vec_hi_q, vec_lo_q};
                    status_out <= (status_in | 8'h04) & 8'hCF;
                    sp_out     <= sp_in - 8'd3;
                    in_service <= in_service | win_q;
                    done       <= 1'b1;
                    state_q    <= StDone;
                end
                StPopP: begin
                    mem_addr <= {8'h01, sp_in + 8'd2};
                    state_q  <= StPopL;
                end
                StPopL: begin
                    pop_p_q  <= mem_rdata;
                    mem_addr <= {8'h01, sp_in + 8'd3};
                    state_q  <= StPopH;
                end
                StPopH: begin
                    pop_l_q <= mem_rdata;
                    state_q <= StFin;
                end
                StFin: begin
                    pc_out     <= {mem_rdata, pop_l_q};
                    status_out <= pop_p_q & 8'hCF;
                    sp_out     <= sp_in + 8'd3;
                    in_service <= in_service & ~isr_low;
                    done       <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: state_q <= StIdle;
                default: begin
                    state_q    <= StIdle;
                    pc_out     <= '0;
                    status_out <= '0;
                    sp_out     <= '0;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                    in_service <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sequencer_n.sv
// Scoreboard bench for irq_sequencer_n: directed sequences push expected bus writes and
// done results; a negedge monitor pops and compares them as the DUT presents them.
module tb_irq_sequencer_n;

    logic        clk = 1'b0;
    logic        rst, halt, start, is_rti, brk;
    logic [3:0]  src_in;
    logic [15:0] pc_in;
    logic [7:0]  status_in, sp_in;
    logic        done, busy, mem_we;
    logic [15:0] pc_out, mem_addr;
    logic [7:0]  status_out, sp_out, mem_wdata, mem_rdata;
    logic [3:0]  pending, in_service;

    irq_sequencer_n dut (
        .clk(clk), .rst(rst), .halt(halt), .start(start), .is_rti(is_rti), .brk(brk),
        .src_in(src_in), .pc_in(pc_in), .status_in(status_in), .sp_in(sp_in),
        .done(done), .busy(busy), .pc_out(pc_out), .status_out(status_out), .sp_out(sp_out),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int start_cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_done;
        int          t;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  st;
        logic [7:0]  sp;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // Bus memory; a halted bus holds its read data.
    logic [7:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFF8] = 8'h34; mem[16'hFFF9] = 8'h12;
        mem[16'hFFFA] = 8'h78; mem[16'hFFFB] = 8'h56;
        mem[16'hFFFC] = 8'hBC; mem[16'hFFFD] = 8'h9A;
        mem[16'hFFFE] = 8'hF0; mem[16'hFFFF] = 8'hDE;
        mem[16'h0181] = 8'hF3; mem[16'h0182] = 8'hCD; mem[16'h0183] = 8'hAB;
        mem[16'h01EB] = 8'h55; mem[16'h01EC] = 8'h66; mem[16'h01ED] = 8'h77;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (!halt) mem_rdata <= mem[mem_addr];
            if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_w(input logic [15:0] a, input logic [7:0] d, input int t);
        q.push_back('{1'b0, t, a, d, 8'h00, 8'h00});
    endtask

    task automatic push_d(input logic [15:0] pc, input logic [7:0] st, input logic [7:0] sp,
                          input int t);
        q.push_back('{1'b1, t, pc, 8'h00, st, sp});
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_write: got %h@%h expected none", mem_wdata, mem_addr);
            end else begin
                mon_e = q.pop_front();
                check("write_kind", 0, int'(mon_e.is_done));
                check("write_time", cyc - start_cyc + 1, mon_e.t);
                check("write_addr", int'(mem_addr), int'(mon_e.a));
                check("write_data", int'(mem_wdata), int'(mon_e.d));
            end
        end
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_done: got pc=%h expected none", pc_out);
            end else begin
                mon_e = q.pop_front();
                check("done_kind", 1, int'(mon_e.is_done));
                check("done_time", cyc - start_cyc + 1, mon_e.t);
                check("pc_out", int'(pc_out), int'(mon_e.a));
                check("status_out", int'(status_out), int'(mon_e.st));
                check("sp_out", int'(sp_out), int'(mon_e.sp));
            end
        end
    end

    task automatic set_src(input logic [3:0] v);
        src_in = v;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic rti, input logic b, input logic [15:0] pc,
                            input logic [7:0] st, input logic [7:0] sp);
        is_rti = rti; brk = b; pc_in = pc; status_in = st; sp_in = sp; start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0; is_rti = 1'b0; brk = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; start = 1'b0; is_rti = 1'b0; brk = 1'b0;
        src_in = 4'h0; pc_in = 16'h0; status_in = 8'h0; sp_in = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pc", int'(pc_out), 0);
        check("rst_status", int'(status_out), 0);
        check("rst_sp", int'(sp_out), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_isr", int'(in_service), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Edge source 0 entry, then RTI back.
        set_src(4'b0001);
        check("pend_src0", int'(pending), 4'b0001);
        push_w(16'h01FD, 8'h81, 3); push_w(16'h01FC, 8'h23, 4); push_w(16'h01FB, 8'h20, 5);
        push_d(16'h1234, 8'h04, 8'hFA, 6);
        do_start(1'b0, 1'b0, 16'h8123, 8'h00, 8'hFD);
        wait_idle();
        check("isr_src0", int'(in_service), 4'b0001);
        check("pend_src0_clr", int'(pending), 4'b0000);
        push_d(16'h8123, 8'h00, 8'hFD, 5);
        do_start(1'b1, 1'b0, 16'h0000, 8'h00, 8'hFA);
        wait_idle();
        check("isr_rti0", int'(in_service), 0);
        set_src(4'b0000);

        // Masked level source 3 passes through; unmasked it is entered, with a halt in T3.
        set_src(4'b1000);
        push_d(16'h4000, 8'h04, 8'hFD, 1);
        do_start(1'b0, 1'b0, 16'h4000, 8'h04, 8'hFD);
        wait_idle();
        push_w(16'h01FD, 8'h40, 4); push_w(16'h01FC, 8'h00, 5); push_w(16'h01FB, 8'h20, 6);
        push_d(16'hDEF0, 8'h04, 8'hFA, 7);
        do_start(1'b0, 1'b0, 16'h4000, 8'h00, 8'hFD);
        @(posedge clk); @(posedge clk); #1;
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        wait_idle();
        check("isr_src3", int'(in_service), 4'b1000);
        set_src(4'b0000);
        push_d(16'h4000, 8'h00, 8'hFD, 5);
        do_start(1'b1, 1'b0, 16'h0000, 8'h00, 8'hFA);
        wait_idle();

        // No-push source 1, then RTI pops F3/CD/AB.
        set_src(4'b0010);
        push_d(16'h5678, 8'h04, 8'h7D, 6);
        do_start(1'b0, 1'b0, 16'h1111, 8'h00, 8'h80);
        wait_idle();
        check("isr_src1", int'(in_service), 4'b0010);
        set_src(4'b0000);
        push_d(16'hABCD, 8'hC3, 8'h83, 5);
        do_start(1'b1, 1'b0, 16'h0000, 8'h00, 8'h80);
        wait_idle();
        check("isr_rti1", int'(in_service), 0);

        // Nesting: source 2 in service, source 1 preempts, two RTIs unwind.
        set_src(4'b0100);
        check("pend_lvl2", int'(pending), 4'b0100);
        push_w(16'h01F0, 8'h22, 3); push_w(16'h01EF, 8'h22, 4); push_w(16'h01EE, 8'h20, 5);
        push_d(16'h9ABC, 8'h04, 8'hED, 6);
        do_start(1'b0, 1'b0, 16'h2222, 8'h00, 8'hF0);
        wait_idle();
        set_src(4'b0110);
        push_d(16'h5678, 8'h04, 8'hEA, 6);
        do_start(1'b0, 1'b0, 16'h3333, 8'h04, 8'hED);
        wait_idle();
        check("isr_nest", int'(in_service), 4'b0110);
        set_src(4'b0000);
        push_d(16'h7766, 8'h45, 8'hED, 5);
        do_start(1'b1, 1'b0, 16'h0000, 8'h00, 8'hEA);
        wait_idle();
        check("isr_unwind1", int'(in_service), 4'b0100);
        push_d(16'h2222, 8'h00, 8'hF0, 5);
        do_start(1'b1, 1'b0, 16'h0000, 8'h00, 8'hED);
        wait_idle();
        check("isr_unwind2", int'(in_service), 0);

        // BRK hijacked by pending source 0: source 0 vector, B still pushed.
        set_src(4'b0001);
        push_w(16'h01FD, 8'h90, 3); push_w(16'h01FC, 8'h00, 4); push_w(16'h01FB, 8'h30, 5);
        push_d(16'h1234, 8'h04, 8'hFA, 6);
        do_start(1'b0, 1'b1, 16'h9000, 8'h00, 8'hFD);
        wait_idle();
        check("pend_brk_clr", int'(pending), 0);
        check("isr_brk", int'(in_service), 4'b0001);
        push_d(16'h9000, 8'h00, 8'hFD, 5);
        do_start(1'b1, 1'b0, 16'h0000, 8'h00, 8'hFA);
        wait_idle();

        // Stack page wrap on entry and on RTI.
        set_src(4'b0000);
        set_src(4'b0001);
        push_w(16'h0101, 8'hAB, 3); push_w(16'h0100, 8'hCD, 4); push_w(16'h01FF, 8'h20, 5);
        push_d(16'h1234, 8'h04, 8'hFE, 6);
        do_start(1'b0, 1'b0, 16'hABCD, 8'h00, 8'h01);
        wait_idle();
        push_d(16'hABCD, 8'h00, 8'h01, 5);
        do_start(1'b1, 1'b0, 16'h0000, 8'h00, 8'hFE);
        wait_idle();
        check("isr_wrap", int'(in_service), 0);

        // Reset in T4 of an entry: two writes, then nothing.
        set_src(4'b0000);
        set_src(4'b0001);
        push_w(16'h0101, 8'h5A, 3); push_w(16'h0100, 8'h5A, 4);
        do_start(1'b0, 1'b0, 16'h5A5A, 8'h00, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_we", int'(mem_we), 0);
        check("mid_rst_addr", int'(mem_addr), 0);
        check("mid_rst_pc", int'(pc_out), 0);
        check("mid_rst_sp", int'(sp_out), 0);
        check("mid_rst_status", int'(status_out), 0);
        check("mid_rst_pending", int'(pending), 0);
        check("mid_rst_isr", int'(in_service), 0);
        src_in = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_queue", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
